sprite_cmd_scheduler: RTL and testbench

SPRITE_CMD_SCHEDULER -- requirements
Module: sprite_cmd_scheduler

---
 rtl/sprite_ctrl_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/sprite_cmd_scheduler.sv | 120 ++++++++++++
 tb/tb_sprite_cmd_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_ctrl_pkg.sv
// Shared types for the sprite control path: info codes, the display bus
// word layout and the command scheduler state encoding.
package sprite_ctrl_pkg;

    // Info codes carried in the info field of a command word.
    localparam logic [3:0] INFO_WRITE = 4'b0001;
    localparam logic [3:0] INFO_FLUSH = 4'b1111;

    // Sprite-display bus word; field order fixes the bit positions
    // (sub_comp[31:26], child[25:21], info[20:17], type[16:14],
    //  pp_selc[13], msg[12:0]).
    typedef struct packed {
        logic [5:0]  sub_comp;
        logic [4:0]  child;
        logic [3:0]  info;
        logic [2:0]  cmd_type;
        logic        pp_selc;
        logic [12:0] msg;
    } disp_word_t;

    // Command scheduler states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_VB,
        FLUSH
    } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push on a full FIFO is accepted only when
// a pop completes in the same cycle; the push_accepted output lets the
// caller detect a dropped push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             push_accepted
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign rdata         = mem[rd_ptr_q];
    assign pop_ok        = pop && !empty;
    assign push_accepted = push && (!full || pop_ok);

    // Next pointer and occupancy values from the accepted push/pop pair.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        wr_ptr_d = push_accepted ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_accepted) - CW'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the empty pointers make stale contents unreachable.
        if (push_accepted) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Sprite command scheduler: buffers host command words, forwards sprite
// writes to the display blocks with the back-buffer index stamped in, and
// turns commit markers into one buffer-swap word per vertical blanking.
module sprite_cmd_scheduler
    import sprite_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [9:0] VBLANK_START = 10'd480,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   host_writedata,
    input  logic          host_write,
    output logic          host_ready,
    input  logic [9:0]    vcount,
    output logic [31:0]   disp_writedata,
    output logic          back_buf,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;
    logic         push_accepted;
    logic [31:0]  fifo_rdata;
    disp_word_t   head;
    logic         in_vblank;

    sched_state_e state_q, state_d;
    disp_word_t   disp_q, disp_d;
    logic         back_buf_q, back_buf_d;
    logic         overflow_q, overflow_d;
    logic         flushed_q, flushed_d;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (host_write),
        .wdata         (host_writedata),
        .pop           (fifo_pop),
        .rdata         (fifo_rdata),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count),
        .push_accepted (push_accepted)
    );

    assign head           = disp_word_t'(fifo_rdata);
    assign in_vblank      = (vcount >= VBLANK_START);
    assign fifo_pop       = ((state_q == IDLE) || (state_q == ISSUE)) && !fifo_empty;
    assign host_ready     = !fifo_full;
    assign disp_writedata = disp_q;
    assign back_buf       = back_buf_q;
    assign overflow       = overflow_q;

    // Next state and next output word; a no-op word is the default.
    always_comb begin
        state_d    = state_q;
        disp_d     = '0;
        back_buf_d = back_buf_q;
        overflow_d = overflow_q || (host_write && !push_accepted);
        // The one-flush-per-blanking latch forgets as soon as blanking ends.
        flushed_d  = flushed_q && in_vblank;

        case (state_q)
            IDLE, ISSUE: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end else if (head.info == INFO_WRITE) begin
                    disp_d         = head;
                    disp_d.pp_selc = back_buf_q;
                    state_d        = ISSUE;
                end else if (head.info == INFO_FLUSH) begin
                    state_d = WAIT_VB;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT_VB: begin
                // The flush word is staged here so it is on the bus during FLUSH.
                if (in_vblank && !flushed_q) begin
                    disp_d.info    = INFO_FLUSH;
                    disp_d.pp_selc = back_buf_q;
                    state_d        = FLUSH;
                end
            end
            FLUSH: begin
                back_buf_d = !back_buf_q;
                flushed_d  = in_vblank;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            disp_q     <= '0;
            back_buf_q <= 1'b1;
            overflow_q <= 1'b0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            back_buf_q <= back_buf_d;
            overflow_q <= overflow_d;
            flushed_q  <= flushed_d;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Self-checking bench for sprite_cmd_scheduler: directed scenarios with
// literal expectations plus a randomized run, all compared every cycle
// against a queue-based behavioural model.
module tb_sprite_cmd_scheduler;

    localparam int         DEPTH = 16;
    localparam logic [9:0] VBS   = 10'd480;

    logic        clk            = 1'b0;
    logic        reset          = 1'b0;
    logic [31:0] host_writedata = '0;
    logic        host_write     = 1'b0;
    logic [9:0]  vcount         = '0;
    logic        host_ready;
    logic [31:0] disp_writedata;
    logic        back_buf;
    logic [4:0]  fifo_count;
    logic        overflow;

    sprite_cmd_scheduler #(
        .FIFO_DEPTH   (DEPTH),
        .VBLANK_START (VBS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_writedata (host_writedata),
        .host_write     (host_write),
        .host_ready     (host_ready),
        .vcount         (vcount),
        .disp_writedata (disp_writedata),
        .back_buf       (back_buf),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        logic [31:0] w;
        int          c;
    } cap_t;
    cap_t cap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    bit          m_wait;   // commit seen, waiting for blanking
    bit          m_flush;  // swap word is on the bus this cycle
    bit          m_done;   // a swap already happened in this blanking interval
    bit          m_buf;
    bit          m_ovf;
    logic [31:0] m_out;

    function automatic logic [31:0] flush_w(input bit b);
        return 32'h001E0000 | (b ? 32'h0000_2000 : 32'h0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wait  = 1'b0;
        m_flush = 1'b0;
        m_done  = 1'b0;
        m_buf   = 1'b1;
        m_ovf   = 1'b0;
        m_out   = '0;
    endtask

    task automatic model_step();
        bit          blank;
        bit          n_wait;
        bit          n_flush;
        bit          n_done;
        bit          n_buf;
        logic [31:0] nxt;
        logic [31:0] w;
        blank   = (vcount >= VBS);
        n_wait  = m_wait;
        n_flush = 1'b0;
        n_done  = blank ? m_done : 1'b0;
        n_buf   = m_buf;
        nxt     = '0;
        if (m_flush) begin
            n_buf = !m_buf;
            if (blank) n_done = 1'b1;
        end else if (m_wait) begin
            if (blank && !m_done) begin
                n_wait  = 1'b0;
                n_flush = 1'b1;
                nxt     = flush_w(m_buf);
            end
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            if (w[20:17] == 4'b0001) begin
                nxt     = w;
                nxt[13] = m_buf;
            end else if (w[20:17] == 4'b1111) begin
                n_wait = 1'b1;
            end
        end
        if (host_write) begin
            if (mq.size() < DEPTH) mq.push_back(host_writedata);
            else m_ovf = 1'b1;
        end
        m_out   = nxt;
        m_wait  = n_wait;
        m_flush = n_flush;
        m_done  = n_done;
        m_buf   = n_buf;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("disp_writedata", disp_writedata, m_out);
            check("back_buf", 32'(back_buf), 32'(m_buf));
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("host_ready", 32'(host_ready), 32'(mq.size() < DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (disp_writedata != 32'h0) cap.push_back('{disp_writedata, cyc});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) model_step();
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        host_write     = 1'b1;
        host_writedata = w;
        tick();
        host_write     = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] info);
        logic [31:0] w;
        w        = $urandom;
        w[20:17] = info;
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp"}, disp_writedata, 32'h0);
        check({tag, "_back_buf"}, 32'(back_buf), 32'd1);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_host_ready"}, 32'(host_ready), 32'd1);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] w[3];
        logic [31:0] wr;
        int          p0;
        bit          bb0;
        int          r;

        // ---- reset ----
        #1 reset = 1'b1;
        model_reset();
        #20;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        idle(2);

        // ---- three writes issue back to back with the back buffer stamped in ----
        cap.delete();
        for (int i = 0; i < 3; i++) begin
            w[i]     = mk(4'b0001);
            w[i][13] = 1'b0;
        end
        push_word(w[0]);
        p0 = cyc;
        push_word(w[1]);
        push_word(w[2]);
        idle(4);
        check("write_count", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++) begin
            check("write_word", cap[i].w, w[i] | 32'h0000_2000);
            check("write_cycle", 32'(cap[i].c), 32'(p0 + 1 + i));
        end

        // ---- commit waits for blanking, then one swap word ----
        vcount = 10'd100;
        cap.delete();
        push_word(mk(4'b1111));
        idle(20);
        check("commit_noop_before_vb", 32'(cap.size()), 32'd0);
        check("commit_buf_before_vb", 32'(back_buf), 32'd1);
        vcount = 10'd480;
        idle(4);
        check("commit_flush_count", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("commit_flush_word", cap[0].w, 32'h001E2000);
        check("commit_buf_after", 32'(back_buf), 32'd0);
        vcount = 10'd0;
        idle(2);

        // ---- fill while waiting for blanking; 17th push dropped ----
        vcount = 10'd100;
        push_word(mk(4'b1111));
        for (int i = 0; i < 16; i++) push_word(mk(($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0101));
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ready", 32'(host_ready), 32'd0);
        check("full_ovf_before", 32'(overflow), 32'd0);
        push_word(mk(4'b0001));
        check("full_ovf_after", 32'(overflow), 32'd1);
        check("full_count_after", 32'(fifo_count), 32'd16);
        vcount = 10'd480;
        idle(25);
        check("drain_count", 32'(fifo_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        vcount = 10'd0;
        idle(2);

        // ---- two commits in one blanking interval ----
        vcount = 10'd490;
        cap.delete();
        bb0 = back_buf;
        push_word(mk(4'b1111));
        push_word(mk(4'b1111));
        idle(10);
        check("two_commit_first_count", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("two_commit_first_word", cap[0].w, flush_w(bb0));
        check("two_commit_buf_mid", 32'(back_buf), 32'(!bb0));
        vcount = 10'd0;
        idle(5);
        check("two_commit_hold", 32'(cap.size()), 32'd1);
        vcount = 10'd480;
        idle(4);
        check("two_commit_second_count", 32'(cap.size()), 32'd2);
        if (cap.size() > 1) check("two_commit_second_word", cap[1].w, flush_w(!bb0));
        check("two_commit_buf_end", 32'(back_buf), 32'(bb0));
        vcount = 10'd0;
        idle(2);

        // ---- unknown info is discarded, next write unaffected ----
        cap.delete();
        wr     = mk(4'b0001);
        wr[13] = 1'b0;
        push_word(mk(4'b0101));
        p0 = cyc;
        push_word(wr);
        idle(3);
        check("discard_count", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) begin
            check("discard_next_word", cap[0].w, wr | 32'h0000_2000);
            check("discard_next_cycle", 32'(cap[0].c), 32'(p0 + 2));
        end

        // ---- randomized traffic across many frames ----
        for (int n = 0; n < 3000; n++) begin
            vcount     = 10'((int'(vcount) + $urandom_range(0, 5)) % 525);
            host_write = ($urandom_range(0, 9) < 6);
            r          = $urandom_range(0, 9);
            if (r <= 5)      host_writedata = mk(4'b0001);
            else if (r == 6) host_writedata = mk(4'b1111);
            else             host_writedata = mk(4'($urandom_range(0, 15)));
            tick();
        end
        host_write = 1'b0;

        // ---- mid-operation reset discards queued work asynchronously ----
        #1 reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("rst_pre");
        tick();
        reset = 1'b0;
        vcount = 10'd480;
        push_word(mk(4'b1111));
        idle(4);
        check("rst_setup_buf", 32'(back_buf), 32'd0);
        vcount = 10'd100;
        push_word(mk(4'b1111));
        for (int i = 0; i < 5; i++) push_word(mk(4'b0001));
        idle(2);
        check("rst_setup_count", 32'(fifo_count), 32'd5);
        #1 reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("rst_async");
        tick();
        reset = 1'b0;
        cap.delete();
        vcount = 10'd480;
        idle(10);
        check("rst_no_flush", 32'(cap.size()), 32'd0);
        check("rst_buf_after", 32'(back_buf), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
